// File: rtl/decode_execute_reg.sv
// decode_execute_reg: ID/EX pipeline register with stall, flush, bubble-valid and multi-cycle MUL hold
module decode_execute_reg #(
  parameter int WIDTH      = 64,
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             ValidD,
  input  logic             PCSrcD,
  input  logic             RegWriteD,
  input  logic             MemToRegD,
  input  logic             MemWriteD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic             NoWriteD,
  input  logic [3:0]       ALUControlD,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] ExtImmD,
  input  logic [4:0]       WA3D,
  output logic             PCSrcE,
  output logic             RegWriteE,
  output logic             MemToRegE,
  output logic             MemWriteE,
  output logic             BranchE,
  output logic             ALUSrcE,
  output logic             NoWriteE,
  output logic [3:0]       ALUControlE,
  output logic [WIDTH-1:0] RD1E,
  output logic [WIDTH-1:0] RD2E,
  output logic [WIDTH-1:0] ExtImmE,
  output logic [4:0]       WA3E,
  output logic             ValidE,
  output logic             MulBusyE,
  output logic             MulDoneE
);
  localparam logic [3:0] MUL_OP = 4'b0010;
  localparam logic [3:0] MUL_N  = 4'(MUL_CYCLES);
  localparam logic       MULTI  = MUL_CYCLES > 1;
  typedef enum logic {IDLE, MUL} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic hold, mul_start;
  assign hold      = StallE | MulBusyE;
  assign mul_start = MULTI && !FlushE && !hold && ValidD && ALUControlD == MUL_OP;
  assign MulBusyE  = state == MUL && cnt > 4'd1;
  // single-cycle builds never enter MUL, so completion is read straight off the E slot
  assign MulDoneE  = MULTI ? (state == MUL && cnt == 4'd1) : (ValidE && ALUControlE == MUL_OP);
  always_comb begin
    state_n = FlushE ? IDLE : mul_start ? MUL : (state == MUL && cnt == 4'd1) ? IDLE : state;
    cnt_n   = FlushE ? 4'd0 : mul_start ? MUL_N : state == MUL ? cnt - 4'd1 : cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  // bubbles keep their side-effect controls low so downstream stages need only check ctrl bits
  always_ff @(posedge clk) begin
    if (reset || FlushE) begin
      PCSrcE      <= 1'b0;
      RegWriteE   <= 1'b0;
      MemToRegE   <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      ALUSrcE     <= 1'b0;
      NoWriteE    <= 1'b0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ExtImmE     <= '0;
      WA3E        <= '0;
      ValidE      <= 1'b0;
    end else if (!hold) begin
      PCSrcE      <= PCSrcD & ValidD;
      RegWriteE   <= RegWriteD & ValidD;
      MemToRegE   <= MemToRegD;
      MemWriteE   <= MemWriteD & ValidD;
      BranchE     <= BranchD & ValidD;
      ALUSrcE     <= ALUSrcD;
      NoWriteE    <= NoWriteD;
      ALUControlE <= ALUControlD;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      ExtImmE     <= ExtImmD;
      WA3E        <= WA3D;
      ValidE      <= ValidD;
    end
  end
endmodule

// File: tb/tb_decode_execute_reg.sv
// tb_decode_execute_reg: vector table, hand-written corner sequences and random stimulus against a residency-count model
module tb_decode_execute_reg;
  typedef struct packed {
    logic        pcsrc, regwrite, memtoreg, memwrite, branch, alusrc, nowrite;
    logic [3:0]  alu;
    logic [63:0] rd1, rd2, imm;
    logic [4:0]  wa3;
    logic        valid;
  } fld_t;
  typedef struct {
    logic rst, stall, flush;
    fld_t d, e;
    logic busy, done;
  } vec_t;
  logic clk = 1'b0;
  logic reset, StallE, FlushE;
  fld_t d, e3, e1, m3, m1;
  logic busy3, done3, busy1, done1;
  int l3, l1;
  int tests = 0;
  int fails = 0;
  vec_t tbl[11];
  always #5 clk = ~clk;
  decode_execute_reg #(.WIDTH(64), .MUL_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(d.valid),
    .PCSrcD(d.pcsrc), .RegWriteD(d.regwrite), .MemToRegD(d.memtoreg), .MemWriteD(d.memwrite),
    .BranchD(d.branch), .ALUSrcD(d.alusrc), .NoWriteD(d.nowrite), .ALUControlD(d.alu),
    .RD1D(d.rd1), .RD2D(d.rd2), .ExtImmD(d.imm), .WA3D(d.wa3),
    .PCSrcE(e3.pcsrc), .RegWriteE(e3.regwrite), .MemToRegE(e3.memtoreg), .MemWriteE(e3.memwrite),
    .BranchE(e3.branch), .ALUSrcE(e3.alusrc), .NoWriteE(e3.nowrite), .ALUControlE(e3.alu),
    .RD1E(e3.rd1), .RD2E(e3.rd2), .ExtImmE(e3.imm), .WA3E(e3.wa3), .ValidE(e3.valid),
    .MulBusyE(busy3), .MulDoneE(done3));
  decode_execute_reg #(.WIDTH(64), .MUL_CYCLES(1)) u1 (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(d.valid),
    .PCSrcD(d.pcsrc), .RegWriteD(d.regwrite), .MemToRegD(d.memtoreg), .MemWriteD(d.memwrite),
    .BranchD(d.branch), .ALUSrcD(d.alusrc), .NoWriteD(d.nowrite), .ALUControlD(d.alu),
    .RD1D(d.rd1), .RD2D(d.rd2), .ExtImmD(d.imm), .WA3D(d.wa3),
    .PCSrcE(e1.pcsrc), .RegWriteE(e1.regwrite), .MemToRegE(e1.memtoreg), .MemWriteE(e1.memwrite),
    .BranchE(e1.branch), .ALUSrcE(e1.alusrc), .NoWriteE(e1.nowrite), .ALUControlE(e1.alu),
    .RD1E(e1.rd1), .RD2E(e1.rd2), .ExtImmE(e1.imm), .WA3E(e1.wa3), .ValidE(e1.valid),
    .MulBusyE(busy1), .MulDoneE(done1));
  function automatic fld_t fld(input logic [3:0] alu, input logic [6:0] c, input logic [63:0] a, b, i,
                               input logic [4:0] w, input logic v);
    fld_t f;
    {f.pcsrc, f.regwrite, f.memtoreg, f.memwrite, f.branch, f.alusrc, f.nowrite} = c;
    f.alu = alu; f.rd1 = a; f.rd2 = b; f.imm = i; f.wa3 = w; f.valid = v;
    return f;
  endfunction
  task automatic cmp(input string name, input logic [210:0] act, input logic [210:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // left = EX cycles still owed by the MUL sitting in E (0 when none)
  task automatic model_edge(inout fld_t me, inout int left, input int n);
    logic busy;
    busy = left > 1;
    if (reset || FlushE) begin
      me = '0; left = 0;
    end else if (StallE || busy) begin
      left = left > 0 ? left - 1 : 0;
    end else begin
      me = d;
      if (!d.valid) begin
        me.pcsrc = 0; me.regwrite = 0; me.memwrite = 0; me.branch = 0;
      end
      left = (d.valid && d.alu == 4'b0010 && n > 1) ? n : 0;
    end
  endtask
  function automatic logic exp_done(input fld_t me, input int left, input int n);
    return n == 1 ? (me.valid && me.alu == 4'b0010) : left == 1;
  endfunction
  task automatic step();
    @(posedge clk);
    model_edge(m3, l3, 3);
    model_edge(m1, l1, 1);
    #1;
    cmp("model_n3", {e3, busy3, done3}, {m3, l3 > 1, exp_done(m3, l3, 3)});
    cmp("model_n1", {e1, busy1, done1}, {m1, l1 > 1, exp_done(m1, l1, 1)});
  endtask
  task automatic rand_d();
    logic [223:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    d = fld_t'(r[208:0]);
    if ($urandom_range(0, 2) == 0) d.alu = 4'b0010;
    d.valid = $urandom_range(0, 4) != 0;
  endtask
  initial begin
    fld_t x1, x2, add, oth, mul, add2, fl, bin, bout, zero;
    x1   = fld(4'hf, 7'h7f, 64'hdead, 64'hbeef, 64'h1234, 5'd31, 1);
    x2   = fld(4'h2, 7'h55, 64'h1111, 64'h2222, 64'h3333, 5'd17, 1);
    add  = fld(4'h0, 7'b0100000, 64'd5, 64'd7, 64'd0, 5'd3, 1);
    oth  = fld(4'h1, 7'b0110110, 64'd9, 64'd9, 64'd9, 5'd9, 1);
    mul  = fld(4'h2, 7'b0100000, 64'd6, 64'd7, 64'd0, 5'd4, 1);
    add2 = fld(4'h0, 7'b0100000, 64'd1, 64'd2, 64'd3, 5'd8, 1);
    fl   = fld(4'h0, 7'b1101100, 64'd1, 64'd1, 64'd1, 5'd1, 1);
    bin  = fld(4'h2, 7'h7f, 64'd3, 64'd4, 64'd5, 5'd6, 0);
    bout = fld(4'h2, 7'b0010011, 64'd3, 64'd4, 64'd5, 5'd6, 0);
    zero = '0;
    tbl[0]  = '{1, 0, 0, x1,   zero, 0, 0};
    tbl[1]  = '{1, 0, 0, x2,   zero, 0, 0};
    tbl[2]  = '{0, 0, 0, add,  add,  0, 0};
    tbl[3]  = '{0, 1, 0, oth,  add,  0, 0};
    tbl[4]  = '{0, 0, 0, mul,  mul,  1, 0};
    tbl[5]  = '{0, 0, 0, oth,  mul,  1, 0};
    tbl[6]  = '{0, 0, 0, oth,  mul,  0, 1};
    tbl[7]  = '{0, 0, 0, add2, add2, 0, 0};
    tbl[8]  = '{0, 1, 1, fl,   zero, 0, 0};
    tbl[9]  = '{0, 0, 0, bin,  bout, 0, 0};
    tbl[10] = '{0, 0, 0, add,  add,  0, 0};
    m3 = '0; m1 = '0; l3 = 0; l1 = 0;
    reset = 1; StallE = 0; FlushE = 0; d = x1;
    for (int i = 0; i < 11; i++) begin
      reset = tbl[i].rst; StallE = tbl[i].stall; FlushE = tbl[i].flush; d = tbl[i].d;
      step();
      cmp($sformatf("vec%0d", i), {e3, busy3, done3}, {tbl[i].e, tbl[i].busy, tbl[i].done});
    end
    d = mul; step();
    cmp("flush_mul_busy_before", 211'(busy3), 211'(1));
    FlushE = 1; d = oth; step();
    cmp("flush_mul_busy", 211'(busy3), 211'(0));
    cmp("flush_mul_done", 211'(done3), 211'(0));
    cmp("flush_mul_valid", 211'(e3.valid), 211'(0));
    FlushE = 0; d = add; step();
    cmp("after_flush_load", {e3, busy3, done3}, {add, 2'b00});
    d = mul; step();
    reset = 1; step();
    cmp("reset_mid_mul", {e3, busy3, done3}, 211'(0));
    reset = 0; d = mul; step();
    cmp("n1_done", 211'({busy1, done1}), 211'(2'b01));
    cmp("n3_busy", 211'({busy3, done3}), 211'(2'b10));
    d = add; step();
    cmp("n1_next", {e1, busy1, done1}, {add, 2'b00});
    cmp("n3_held", e3, mul);
    step(); step();
    for (int i = 0; i < 600; i++) begin
      rand_d();
      reset  = $urandom_range(0, 49) == 0;
      StallE = $urandom_range(0, 4) == 0;
      FlushE = $urandom_range(0, 11) == 0;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
